aes_dec_round_sequencer: RTL and testbench
==========================================

Name: aes_dec_round_sequencer

Overview:
- Top-level schedule controller for the AES decrypt datapath.
- Runs the per-round kernels in inverse-cipher order through their ap_start/ap_done handshakes: AddRoundKey (ARK), InvShiftRow+ByteSub (ISB) and InvMixColumn (IMC).
- Drives the round index n into ARK and selects which kernel owns the shared statemt RAM ports.
- Sits between the decrypt top wrapper and the three kernels.

Parameters:
- RW, 5, width of round index / nb_rounds (matches ARK n port)
- MAX_ROUNDS, 14, largest accepted nb_rounds

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  request decrypt of one block
- nb_rounds  in  RW  round count; 10, 12 or 14 legal; sampled on accept
- ap_done  out  1  one-cycle pulse, block finished
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- ap_idle  out  1  high in IDLE when ap_start low
- ap_err  out  1  one-cycle pulse, illegal nb_rounds rejected
- ark_start  out  1  AddRoundKey start
- ark_done  in  1  AddRoundKey done pulse
- ark_n  out  RW  round index to AddRoundKey
- isb_start  out  1  InvShiftRow+ByteSub start
- isb_done  in  1  InvShiftRow+ByteSub done pulse
- imc_start  out  1  InvMixColumn start
- imc_done  in  1  InvMixColumn done pulse
- mem_sel  out  2  statemt port owner: 0 ARK, 1 ISB, 2 IMC, 3 none
- round  out  RW  current round counter (status)

Behaviour:
- Reset (async, ap_rst_n=0):
  - state=IDLE; all *_start=0; ap_done=ap_ready=ap_err=0; mem_sel=3; ark_n=0; round=0.
  - Takes effect immediately, including mid-block. Kernels are not notified; the wrapper resets them too.
- States: IDLE, ARK_INIT, ISB, ARK, IMC, ISB_FIN, ARK_FIN, DONE, ERR.
- IDLE:
  - Accept when ap_start=1.
  - nb_rounds in {10,12,14} -> latch nb_rounds, round<=nb_rounds, go to ARK_INIT.
  - Otherwise -> ERR.
- ERR: ap_err=1 for one cycle -> IDLE. No kernel is started.
- Issuing states:
  - Each issuing state holds its kernel's start=1 and mem_sel=owner for every cycle it is resident.
  - It leaves on the first edge where that kernel's done=1, including the first cycle of the state.
  - Done inputs of non-active kernels are ignored, in every state.
- Sequence:
  - ARK_INIT: ark_n=round (nb_rounds) -> round<=round-1 -> ISB.
  - ISB -> ARK.
  - ARK: ark_n=round -> IMC.
  - IMC: round>1 ? round<=round-1, go to ISB : round<=0, go to ISB_FIN.
  - ISB_FIN -> ARK_FIN.
  - ARK_FIN: ark_n=0 -> DONE.
- Kernel invocations per block: 3*nb_rounds. ark_n values in order: nb_rounds, nb_rounds-1, ..., 0.
- Outside ARK states, ark_n holds its last value.
- DONE: ap_done=ap_ready=1 for one cycle, mem_sel=3 -> IDLE.
  - ap_start high in IDLE is accepted on the next edge, so back-to-back blocks have a 1-cycle IDLE gap.
- Latency: with every kernel returning done in cycle L of its start, ap_done is high in the cycle after edge 3*nb_rounds*L following the accept edge.
- ap_start changes after accept are ignored until IDLE. nb_rounds changes mid-block are ignored (latched copy used).
- Round arithmetic: unsigned RW bits; never decremented below 0.
- Default FSM branch -> IDLE with all outputs at reset values.

Decomposition:
- Package aes_dec_pkg holds:
  - state enum
  - MEM_SEL_ARK/ISB/IMC/NONE codes
  - legal round constants 10/12/14, MAX_ROUNDS
- Single module: FSM plus round counter; no sub-module needed.

Test Plan:
- nb_rounds=10, all kernel stubs L=3, ap_start pulse:
  - 30 starts in order ARK,ISB,ARK,IMC,...,ISB,ARK.
  - ark_n sequence 10..0.
  - ap_done in the cycle after edge 90.
  - mem_sel always matches the active kernel.
- nb_rounds=14, L=1: 42 invocations, ap_done after edge 42, round=0 at DONE.
- nb_rounds=7: ap_err pulses 1 cycle after accept; no *_start ever high; back to IDLE with ap_idle=1 once ap_start is low.
- Spurious done: isb_done/imc_done pulsed during an ARK stage and in IDLE -> no state change, no extra invocation.
- ap_rst_n dropped during the IMC of round 5 -> all starts 0 and mem_sel=3 immediately. After release, ap_start with nb_rounds=12 runs a full clean block (ark_n starts at 12).
- ap_start held high across two blocks (nb_rounds=10, L=2) -> two ap_done pulses 62 cycles apart.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt round sequencer.
//   state_t          : sequencer FSM states
//   MEM_SEL_*        : owner codes for the shared statemt RAM ports
//   ROUNDS_10/12/14  : legal round counts
//   MAX_ROUNDS       : largest accepted round count
package aes_dec_pkg;

    localparam int RW         = 5;
    localparam int MAX_ROUNDS = 14;
    localparam int ROUNDS_10  = 10;
    localparam int ROUNDS_12  = 12;
    localparam int ROUNDS_14  = 14;

    localparam logic [1:0] MEM_SEL_ARK  = 2'd0;
    localparam logic [1:0] MEM_SEL_ISB  = 2'd1;
    localparam logic [1:0] MEM_SEL_IMC  = 2'd2;
    localparam logic [1:0] MEM_SEL_NONE = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARK_INIT,
        S_ISB,
        S_ARK,
        S_IMC,
        S_ISB_FIN,
        S_ARK_FIN,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/aes_dec_round_sequencer.sv
// Schedule controller for the AES decrypt datapath. Runs AddRoundKey (ARK),
// InvShiftRow+ByteSub (ISB) and InvMixColumn (IMC) in inverse-cipher order
// through their start/done handshakes, drives the ARK round index and selects
// the owner of the shared statemt RAM ports.
//
// Handshake: a kernel's start is held high for every cycle the sequencer sits
// in that kernel's issuing state; the kernel completes on the first rising
// edge at which its done is high (possibly the first cycle). done inputs of
// kernels that are not currently started are ignored.
//
// Ports:
//   ap_clk, ap_rst_n      clock, asynchronous active-low reset
//   ap_start, nb_rounds   block request and round count (10/12/14)
//   ap_done, ap_ready     one-cycle pulses when the block is finished
//   ap_idle               idle and no request pending
//   ap_err                one-cycle pulse when nb_rounds is rejected
//   ark_start/done, ark_n AddRoundKey handshake and round index
//   isb_start/done        InvShiftRow+ByteSub handshake
//   imc_start/done        InvMixColumn handshake
//   mem_sel               statemt owner: 0 ARK, 1 ISB, 2 IMC, 3 none
//   round                 current round counter (status)
module aes_dec_round_sequencer
    import aes_dec_pkg::*;
#(
    parameter int RW         = 5,
    parameter int MAX_ROUNDS = 14
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          ap_start,
    input  logic [RW-1:0] nb_rounds,
    output logic          ap_done,
    output logic          ap_ready,
    output logic          ap_idle,
    output logic          ap_err,
    output logic          ark_start,
    input  logic          ark_done,
    output logic [RW-1:0] ark_n,
    output logic          isb_start,
    input  logic          isb_done,
    output logic          imc_start,
    input  logic          imc_done,
    output logic [1:0]    mem_sel,
    output logic [RW-1:0] round
);

    state_t        state, state_nxt;
    logic [RW-1:0] round_q, round_nxt;
    logic [RW-1:0] nb_q, nb_nxt;
    logic [RW-1:0] ark_n_q, ark_n_nxt;
    logic          legal;

    assign legal = (nb_rounds <= RW'(MAX_ROUNDS)) &&
                   ((nb_rounds == RW'(ROUNDS_10)) ||
                    (nb_rounds == RW'(ROUNDS_12)) ||
                    (nb_rounds == RW'(ROUNDS_14)));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            round_q <= '0;
            nb_q    <= '0;
            ark_n_q <= '0;
        end else begin
            state   <= state_nxt;
            round_q <= round_nxt;
            nb_q    <= nb_nxt;
            ark_n_q <= ark_n_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        round_nxt = round_q;
        nb_nxt    = nb_q;
        ark_n_nxt = ark_n_q;   // ark_n holds outside the ARK states
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ap_idle   = 1'b0;
        ap_err    = 1'b0;
        ark_start = 1'b0;
        isb_start = 1'b0;
        imc_start = 1'b0;
        mem_sel   = MEM_SEL_NONE;
        case (state)
            S_IDLE: begin
                ap_idle = !ap_start;
                if (ap_start) begin
                    if (legal) begin
                        nb_nxt    = nb_rounds;
                        round_nxt = nb_rounds;
                        state_nxt = S_ARK_INIT;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_ARK_INIT: begin
                ark_start = 1'b1;
                mem_sel   = MEM_SEL_ARK;
                ark_n_nxt = nb_q;
                if (ark_done) begin
                    if (round_q != '0) round_nxt = round_q - 1'b1;
                    state_nxt = S_ISB;
                end
            end
            S_ISB: begin
                isb_start = 1'b1;
                mem_sel   = MEM_SEL_ISB;
                if (isb_done) state_nxt = S_ARK;
            end
            S_ARK: begin
                ark_start = 1'b1;
                mem_sel   = MEM_SEL_ARK;
                ark_n_nxt = round_q;
                if (ark_done) state_nxt = S_IMC;
            end
            S_IMC: begin
                imc_start = 1'b1;
                mem_sel   = MEM_SEL_IMC;
                if (imc_done) begin
                    // Round 1 is the last full round; the final round skips IMC.
                    if (round_q > RW'(1)) begin
                        round_nxt = round_q - 1'b1;
                        state_nxt = S_ISB;
                    end else begin
                        round_nxt = '0;
                        state_nxt = S_ISB_FIN;
                    end
                end
            end
            S_ISB_FIN: begin
                isb_start = 1'b1;
                mem_sel   = MEM_SEL_ISB;
                if (isb_done) state_nxt = S_ARK_FIN;
            end
            S_ARK_FIN: begin
                ark_start = 1'b1;
                mem_sel   = MEM_SEL_ARK;
                ark_n_nxt = '0;
                if (ark_done) state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                ap_err    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                round_nxt = '0;
                nb_nxt    = '0;
                ark_n_nxt = '0;
            end
        endcase
    end

    assign ark_n = ark_n_nxt;
    assign round = round_q;

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Bench for aes_dec_round_sequencer: kernel stubs with programmable latency,
// an expected-event queue filled by the stimulus, and a monitor that pops and
// compares on every kernel completion, ap_done and ap_err.
module tb_aes_dec_round_sequencer;

    localparam int RW = 5;
    localparam logic [2:0] K_ARK  = 3'd0;
    localparam logic [2:0] K_ISB  = 3'd1;
    localparam logic [2:0] K_IMC  = 3'd2;
    localparam logic [2:0] K_DONE = 3'd3;
    localparam logic [2:0] K_ERR  = 3'd4;

    // ---------------- clock / reset ----------------
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic          ap_start = 1'b0;
    logic [RW-1:0] nb_rounds = '0;
    logic          ap_done, ap_ready, ap_idle, ap_err;
    logic          ark_start, isb_start, imc_start;
    logic          ark_done, isb_done, imc_done;
    logic [RW-1:0] ark_n, round;
    logic [1:0]    mem_sel;

    aes_dec_round_sequencer #(.RW(RW), .MAX_ROUNDS(14)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .nb_rounds(nb_rounds), .ap_done(ap_done), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_err(ap_err),
        .ark_start(ark_start), .ark_done(ark_done), .ark_n(ark_n),
        .isb_start(isb_start), .isb_done(isb_done),
        .imc_start(imc_start), .imc_done(imc_done),
        .mem_sel(mem_sel), .round(round)
    );

    // ---------------- kernel stubs ----------------
    int lat = 1;
    int ark_cnt = 0, isb_cnt = 0, imc_cnt = 0;
    logic ark_force = 1'b0, isb_force = 1'b0, imc_force = 1'b0;
    logic spur_ark = 1'b0;

    assign ark_done = (ark_start && ark_cnt == lat - 1) || ark_force;
    assign isb_done = (isb_start && isb_cnt == lat - 1) || isb_force;
    assign imc_done = (imc_start && imc_cnt == lat - 1) || imc_force;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ark_cnt <= 0; isb_cnt <= 0; imc_cnt <= 0;
        end else begin
            ark_cnt <= (!ark_start || ark_done) ? 0 : ark_cnt + 1;
            isb_cnt <= (!isb_start || isb_done) ? 0 : isb_cnt + 1;
            imc_cnt <= (!imc_start || imc_done) ? 0 : imc_cnt + 1;
        end
    end

    // Spurious ISB/IMC done while an ARK stage is active.
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            isb_force = spur_ark && ark_start;
            imc_force = spur_ark && ark_start;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input logic [7:0] act);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got event 0x%0h expected none at %0t", act, $time);
        end else begin
            e = exp_q.pop_front();
            check("sb_event", int'(act), int'(e));
        end
    endtask

    task automatic push_block(input int nb);
        exp_q.push_back({K_ARK, 5'(nb)});
        for (int r = nb - 1; r >= 1; r--) begin
            exp_q.push_back({K_ISB, 5'd0});
            exp_q.push_back({K_ARK, 5'(r)});
            exp_q.push_back({K_IMC, 5'd0});
        end
        exp_q.push_back({K_ISB, 5'd0});
        exp_q.push_back({K_ARK, 5'd0});
        exp_q.push_back({K_DONE, 5'd0});
    endtask

    // Monitor: samples on the falling edge.
    initial begin
        int exp_sel;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n) begin
                exp_sel = ark_start ? 0 : isb_start ? 1 : imc_start ? 2 : 3;
                check("mem_sel", int'(mem_sel), exp_sel);
                check("start_onehot", int'(ark_start) + int'(isb_start) + int'(imc_start) <= 1, 1);
                if (ark_start && ark_done) sb_pop({K_ARK, ark_n});
                if (isb_start && isb_done) sb_pop({K_ISB, 5'd0});
                if (imc_start && imc_done) sb_pop({K_IMC, 5'd0});
                if (ap_done) begin
                    sb_pop({K_DONE, round});
                    check("ap_ready", int'(ap_ready), 1);
                end
                if (ap_err) sb_pop({K_ERR, 5'd0});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(posedge ap_clk);
            n++;
            @(negedge ap_clk);
            if (ap_done) break;
            if (n >= 3000) begin
                check("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic issue(input int nb);
        @(posedge ap_clk);
        #1;
        ap_start  = 1'b1;
        nb_rounds = RW'(nb);
        @(posedge ap_clk);   // accept edge
        #1;
        ap_start  = 1'b0;
        nb_rounds = RW'(3);  // mid-block change must be ignored
    endtask

    task automatic run_block(input int nb, input int l, input int exp_edges);
        int n;
        lat = l;
        push_block(nb);
        issue(nb);
        wait_done(n);
        check("latency", n, exp_edges);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int hit;
        // Reset state
        #12;
        check("rst_starts", int'({ark_start, isb_start, imc_start}), 0);
        check("rst_flags", int'({ap_done, ap_ready, ap_err}), 0);
        check("rst_mem_sel", int'(mem_sel), 3);
        check("rst_ark_n", int'(ark_n), 0);
        check("rst_round", int'(round), 0);
        check("rst_idle", int'(ap_idle), 1);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;

        // Full blocks
        run_block(10, 3, 90);
        run_block(14, 1, 42);

        // Illegal round count
        exp_q.push_back({K_ERR, 5'd0});
        issue(7);
        @(negedge ap_clk);
        check("err_pulse", int'(ap_err), 1);
        check("err_no_start", int'({ark_start, isb_start, imc_start}), 0);
        @(negedge ap_clk);
        check("err_once", int'(ap_err), 0);
        check("err_no_start2", int'({ark_start, isb_start, imc_start}), 0);
        check("err_idle", int'(ap_idle), 1);

        // Spurious done in IDLE
        @(posedge ap_clk);
        #1;
        ark_force = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            check("idle_spur", int'(ap_idle), 1);
        end
        @(posedge ap_clk);
        #1;
        ark_force = 1'b0;

        // Spurious ISB/IMC done during ARK stages
        spur_ark = 1'b1;
        run_block(10, 1, 30);
        spur_ark = 1'b0;

        // Reset during IMC of round 5
        lat = 1;
        push_block(10);
        issue(10);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ap_clk);
            if (imc_start && round == 5) begin
                hit = 1;
                break;
            end
        end
        check("reach_imc5", hit, 1);
        #1;
        ap_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_starts", int'({ark_start, isb_start, imc_start}), 0);
        check("mid_rst_mem_sel", int'(mem_sel), 3);
        check("mid_rst_round", int'(round), 0);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        run_block(12, 2, 72);

        // ap_start held high across two blocks
        lat = 2;
        push_block(10);
        push_block(10);
        @(posedge ap_clk);
        #1;
        ap_start  = 1'b1;
        nb_rounds = RW'(10);
        wait_done(n);
        check("b2b_first", n, 61);
        @(posedge ap_clk);   // DONE -> IDLE
        @(posedge ap_clk);   // second accept
        #1;
        ap_start = 1'b0;
        wait_done(n);
        check("b2b_gap", n + 2, 62);

        repeat (3) @(negedge ap_clk);
        check("sb_drained", exp_q.size(), 0);
        check("final_idle", int'(ap_idle), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
